// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the memory-port arbiter and its two requesters plus the downstream bus.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_flush_i;
    logic [DATA_W-1:0]     if_rdata_o;
    logic                  if_done_o;
    logic                  if_stall_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [ADDR_W-1:0]     mem_addr_i;
    logic [DATA_W-1:0]     mem_wdata_i;
    logic [DATA_W/8-1:0]   mem_wstrb_i;
    logic [DATA_W-1:0]     mem_rdata_o;
    logic                  mem_done_o;
    logic                  mem_stall_o;

    logic                  bus_valid_o;
    logic                  bus_ready_i;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W/8-1:0]   bus_wstrb_o;
    logic                  bus_resp_valid_i;
    logic [DATA_W-1:0]     bus_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_rdata_o, if_done_o, if_stall_o,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        output mem_rdata_o, mem_done_o, mem_stall_o,
        output bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_ready_i, bus_resp_valid_i, bus_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_rdata_o, if_done_o, if_stall_o,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        input  mem_rdata_o, mem_done_o, mem_stall_o,
        input  bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_ready_i, bus_resp_valid_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory port between fetch and load/store, with one transaction in flight.
// Load/store has priority, and a starvation counter bounds how long fetch can be passed over.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus_if
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                flush_q, flush_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;

    logic ifElig, memElig, grantMem, grantIf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            starve_q    <= '0;
            flush_q     <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            starve_q    <= starve_d;
            flush_q     <= flush_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // A requester whose done pulse is high is still holding its old request, so it sits out this round.
    always_comb begin
        ifElig   = bus_if.if_req_i & ~if_done_q;
        memElig  = bus_if.mem_req_i & ~mem_done_q;
        grantMem = memElig & (~ifElig | (starve_q < LIMIT));
        grantIf  = ifElig & ~grantMem;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        starve_d    = starve_q;
        flush_d     = flush_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                if (grantMem) begin
                    owner_d  = 1'b1;
                    addr_d   = bus_if.mem_addr_i;
                    we_d     = bus_if.mem_we_i;
                    wdata_d  = bus_if.mem_wdata_i;
                    wstrb_d  = bus_if.mem_wstrb_i;
                    starve_d = !bus_if.if_req_i ? '0 :
                               (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
                    state_d  = ADDR;
                end else if (grantIf) begin
                    owner_d  = 1'b0;
                    addr_d   = bus_if.if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    starve_d = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (!owner_q && bus_if.if_flush_i) flush_d = 1'b1;
                if (bus_if.bus_ready_i) state_d = RESP;
            end
            RESP: begin
                if (!owner_q && bus_if.if_flush_i) flush_d = 1'b1;
                // A flush arriving alongside the response still discards it.
                if (bus_if.bus_resp_valid_i) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    if (owner_q) begin
                        mem_rdata_d = bus_if.bus_rdata_i;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d  = bus_if.bus_rdata_i;
                        if_done_d   = ~(flush_q | bus_if.if_flush_i);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_if.bus_valid_o = (state_q == ADDR);
        bus_if.bus_we_o    = we_q;
        bus_if.bus_addr_o  = addr_q;
        bus_if.bus_wdata_o = wdata_q;
        bus_if.bus_wstrb_o = wstrb_q;
        bus_if.if_rdata_o  = if_rdata_q;
        bus_if.mem_rdata_o = mem_rdata_q;
        bus_if.if_done_o   = if_done_q;
        bus_if.mem_done_o  = mem_done_q;
        bus_if.if_stall_o  = bus_if.if_req_i & ~if_done_q;
        bus_if.mem_stall_o = bus_if.mem_req_i & ~mem_done_q;
    end
endmodule
